// File: rtl/pcs_descrambler_257b.sv
// 257b transcoded-block descrambler (1 + x^39 + x^58) with header-based
// lock tracking and a saturating header-error counter.
module pcs_descrambler_257b #(
    parameter int TRANSCODER_WIDTH = 257,
    parameter int LOCK_CNT         = 4,
    parameter int UNLOCK_CNT       = 3,
    parameter int ERR_CNT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    input  logic [TRANSCODER_WIDTH-1:0] i_scrambled,
    input  logic                        i_clear_err,
    output logic                        o_valid,
    output logic [TRANSCODER_WIDTH-1:0] o_data,
    output logic                        o_primed,
    output logic                        o_locked,
    output logic                        o_hdr_err,
    output logic [ERR_CNT_WIDTH-1:0]    o_hdr_err_count
);

    localparam int PW  = TRANSCODER_WIDTH - 1;
    localparam int SW  = 58;
    localparam int TAP = 39;
    localparam int CW  = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    logic [SW-1:0]               state_q;
    logic                        loaded_q;
    lock_state_t                 lock_q;
    lock_state_t                 lock_d;
    logic [CW-1:0]               good_q;
    logic [CW-1:0]               good_d;
    logic [CW-1:0]               bad_q;
    logic [CW-1:0]               bad_d;
    logic                        err_inc;
    logic                        hdr_bad;
    logic [PW+SW-1:0]            ext;
    logic [PW-1:0]               pay;
    logic [TRANSCODER_WIDTH-1:0] desc;

    // ext[j] for j < SW is history; ext[k+SW] is received payload bit k
    assign ext = {i_scrambled[TRANSCODER_WIDTH-1:1], state_q};

    always_comb begin
        pay = '0;
        for (int k = 0; k < PW; k++) begin
            pay[k] = ext[k+SW] ^ ext[k+SW-TAP] ^ ext[k];
        end
    end

    assign desc = {pay, i_scrambled[0]};

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= '0;
            loaded_q <= 1'b0;
        end else if (i_valid) begin
            state_q  <= i_scrambled[TRANSCODER_WIDTH-1 -: SW];
            loaded_q <= 1'b1;
        end
    end

    always_comb begin
        lock_d  = lock_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_inc = 1'b0;
        hdr_bad = 1'b0;
        // only blocks descrambled with a fully loaded state are judged
        if (i_valid && loaded_q) begin
            hdr_bad = ~desc[0] && (desc[4:1] == 4'b1111);
            unique case (lock_q)
                UNLOCKED: begin
                    if (hdr_bad) begin
                        good_d = '0;
                    end else if (good_q == CW'(LOCK_CNT - 1)) begin
                        lock_d = LOCKED;
                        good_d = '0;
                        bad_d  = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (hdr_bad) begin
                        err_inc = 1'b1;
                        if (bad_q == CW'(UNLOCK_CNT - 1)) begin
                            lock_d = UNLOCKED;
                            good_d = '0;
                            bad_d  = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: lock_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            lock_q <= UNLOCKED;
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            lock_q <= lock_d;
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign o_locked = (lock_q == LOCKED);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_hdr_err <= 1'b0;
            o_primed  <= 1'b0;
            o_data    <= '0;
        end else begin
            o_valid   <= i_valid;
            o_hdr_err <= hdr_bad;
            if (i_valid) begin
                o_data   <= desc;
                o_primed <= loaded_q;
            end
        end
    end

    // clear takes priority over a coincident increment
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_hdr_err_count <= '0;
        end else if (i_clear_err) begin
            o_hdr_err_count <= '0;
        end else if (err_inc && (o_hdr_err_count != '1)) begin
            o_hdr_err_count <= o_hdr_err_count + ERR_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pcs_descrambler_257b.sv
// Directed bench for pcs_descrambler_257b; a second instance with a
// narrow counter exercises saturation.
module tb_pcs_descrambler_257b;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_valid = 1'b0;
    logic [256:0] i_scrambled = '0;
    logic         i_clear_err = 1'b0;
    logic         o_valid;
    logic [256:0] o_data;
    logic         o_primed;
    logic         o_locked;
    logic         o_hdr_err;
    logic [15:0]  o_hdr_err_count;
    logic         s_valid;
    logic [256:0] s_data;
    logic         s_primed;
    logic         s_locked;
    logic         s_hdr_err;
    logic [2:0]   s_hdr_err_count;

    int n_chk = 0;
    int n_err = 0;

    logic [256:0] zero_blk = '0;
    logic [256:0] bad_blk;
    logic [256:0] bad_exp;
    logic [256:0] exp;
    logic [256:0] blk;
    logic [256:0] lb_prev;
    logic [57:0]  scr_st;

    always #5 clk = ~clk;

    pcs_descrambler_257b u_dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_valid         (i_valid),
        .i_scrambled     (i_scrambled),
        .i_clear_err     (i_clear_err),
        .o_valid         (o_valid),
        .o_data          (o_data),
        .o_primed        (o_primed),
        .o_locked        (o_locked),
        .o_hdr_err       (o_hdr_err),
        .o_hdr_err_count (o_hdr_err_count)
    );

    pcs_descrambler_257b #(
        .UNLOCK_CNT    (15),
        .ERR_CNT_WIDTH (3)
    ) u_sat (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_valid         (i_valid),
        .i_scrambled     (i_scrambled),
        .i_clear_err     (i_clear_err),
        .o_valid         (s_valid),
        .o_data          (s_data),
        .o_primed        (s_primed),
        .o_locked        (s_locked),
        .o_hdr_err       (s_hdr_err),
        .o_hdr_err_count (s_hdr_err_count)
    );

    task automatic check(input string tag, input logic [256:0] got,
                         input logic [256:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    task automatic rst_dut();
        @(negedge clk);
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_clear_err = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    // drive one block; returns at the negedge where its result is visible
    task automatic push(input logic [256:0] b);
        @(negedge clk);
        i_valid = 1'b1;
        i_scrambled = b;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic clr();
        @(negedge clk);
        i_clear_err = 1'b1;
        @(negedge clk);
        i_clear_err = 1'b0;
    endtask

    function automatic logic [256:0] scramble(input logic [256:0] d);
        logic [313:0] e;
        e = '0;
        e[57:0] = scr_st;
        for (int k = 0; k < 256; k++) e[k+58] = d[k+1] ^ e[k+19] ^ e[k];
        scr_st = e[313:256];
        return {e[313:58], d[0]};
    endfunction

    initial begin
        bad_blk = '0;
        bad_blk[4:1] = 4'b1111;
        bad_exp = '0;
        for (int j = 0; j < 4; j++) begin
            bad_exp[1+j] = 1'b1;
            bad_exp[40+j] = 1'b1;
            bad_exp[59+j] = 1'b1;
        end

        rst_dut();
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_primed", o_primed, 0);
        check("rst_locked", o_locked, 0);
        check("rst_count", o_hdr_err_count, 0);

        // zero stream: primed from 2nd block, lock on 5th
        for (int k = 1; k <= 6; k++) begin
            push(zero_blk);
            check("z_valid", o_valid, 1);
            check("z_data", o_data, 0);
            check("z_primed", o_primed, k > 1);
            check("z_locked", o_locked, k >= 5);
        end
        @(negedge clk);
        check("gap_valid", o_valid, 0);

        // three bad headers while locked drop lock
        for (int k = 1; k <= 3; k++) begin
            push(bad_blk);
            check("bad_data", o_data, bad_exp);
            check("bad_err", o_hdr_err, 1);
            check("bad_count", o_hdr_err_count, 16'(k));
            check("bad_locked", o_locked, k < 3);
        end
        @(negedge clk);
        check("hold_data", o_data, bad_exp);
        check("hold_err", o_hdr_err, 0);
        clr();
        check("clr_count", o_hdr_err_count, 0);
        for (int k = 1; k <= 4; k++) push(zero_blk);
        check("relock", o_locked, 1);
        push(bad_blk);
        push(bad_blk);
        push(zero_blk);
        check("keep_err", o_hdr_err, 0);
        check("keep_locked", o_locked, 1);
        check("keep_count", o_hdr_err_count, 2);

        // asynchronous reset mid-stream
        @(negedge clk);
        i_valid = 1'b1;
        i_scrambled = bad_blk;
        @(negedge clk);
        i_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_data", o_data, 0);
        check("arst_locked", o_locked, 0);
        check("arst_err", o_hdr_err, 0);
        check("arst_count", o_hdr_err_count, 0);
        @(negedge clk);
        i_rst = 1'b0;

        // single payload bit hits taps 0, 39, 58
        blk = '0;
        blk[1] = 1'b1;
        push(blk);
        exp = '0;
        exp[1] = 1'b1;
        exp[40] = 1'b1;
        exp[59] = 1'b1;
        check("tap_data", o_data, exp);
        check("tap_sat", s_data, exp);
        check("tap_primed", o_primed, 0);

        // state carried across a gap
        blk = '0;
        blk[256] = 1'b1;
        push(blk);
        exp = '0;
        exp[256] = 1'b1;
        check("top_data", o_data, exp);
        repeat (5) @(negedge clk);
        check("gap5_valid", o_valid, 0);
        push(zero_blk);
        exp = '0;
        exp[39] = 1'b1;
        exp[58] = 1'b1;
        check("carry_data", o_data, exp);
        check("carry_primed", o_primed, 1);
        push(zero_blk);
        check("g_unlocked", o_locked, 0);
        repeat (7) @(negedge clk);
        check("g_valid", o_valid, 0);
        push(zero_blk);
        check("g_locked", o_locked, 1);
        check("g_data", o_data, 0);

        // loopback against a reference scrambler
        rst_dut();
        scr_st = '0;
        lb_prev = '0;
        for (int i = 0; i <= 200; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("lb_data", o_data, lb_prev);
                if (i == 4) check("lb_unlocked", o_locked, 0);
                if (i == 5) check("lb_locked", o_locked, 1);
            end
            if (i < 200) begin
                for (int j = 0; j < 257; j++) blk[j] = 1'($urandom_range(0, 1));
                if (!blk[0] && blk[4:1] == 4'b1111) blk[1] = 1'b0;
                lb_prev = blk;
                i_scrambled = scramble(blk);
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
        end
        check("lb_count", o_hdr_err_count, 0);
        check("lb_final_lock", o_locked, 1);

        // saturation on the 3-bit instance
        rst_dut();
        for (int k = 1; k <= 5; k++) push(zero_blk);
        check("sat_locked", s_locked, 1);
        for (int k = 1; k <= 6; k++) push(bad_blk);
        check("sat_count6", s_hdr_err_count, 6);
        for (int k = 1; k <= 3; k++) push(bad_blk);
        check("sat_count7", s_hdr_err_count, 7);
        check("sat_still", s_locked, 1);
        check("unl_err", o_hdr_err, 1);
        check("unl_count", o_hdr_err_count, 3);
        @(negedge clk);
        i_valid = 1'b1;
        i_scrambled = bad_blk;
        i_clear_err = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_clear_err = 1'b0;
        check("clrwin_sat", s_hdr_err_count, 0);
        check("clrwin_err", s_hdr_err, 1);
        check("clrwin_main", o_hdr_err_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
